sd_block_read: RTL and testbench

SPI-mode single-block reader for the SD card path. It sits downstream of the SD initialisation stage and upstream of the UART FIFO controller. Once the card is initialised, it issues CMD17 for a requested block and collects the R1 response and the 0xFE start token. It then streams the 512 data bytes out one per strobe and reports completion or error, which drives the controller's SD-read-done input.

---
 rtl/sd_block_read.sv | 211 +++++++++++++++++++++
 tb/tb_sd_block_read.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_block_read.sv
// SPI-mode CMD17 single-block reader: command, R1, start token, 512 data bytes, CRC, trailer.
// Optional CRC-16 check of the data block is built when SD_RD_CRC_EN is defined.
module sd_block_read #(
  parameter int CLK_DIV     = 4,
  parameter int R1_TRIES    = 8,
  parameter int TOKEN_TRIES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        init_ok,
  input  logic        start,
  input  logic [31:0] blk_addr,
  output logic        sd_ck,
  output logic        sd_mosi,
  output logic        sd_csn,
  input  logic        sd_miso,
  output logic        busy,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic        done,
  output logic [1:0]  err
);
  localparam int DW   = $clog2(CLK_DIV);
  localparam int PMAX = (R1_TRIES > TOKEN_TRIES) ? R1_TRIES : TOKEN_TRIES;
  localparam int PW   = $clog2(PMAX + 1);

  typedef enum logic [2:0] {IDLE, PRE, CMD, R1, TOKEN, DATA, CRC, POST} state_t;

  state_t          state;
  logic [DW-1:0]   div_cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      tx_sr;
  logic [7:0]      rx_sr;
  logic [2:0]      byte_cnt;
  logic [PW-1:0]   poll_cnt;
  logic [8:0]      data_cnt;
  logic [31:0]     addr;
  logic [7:0]      nxt_cmd;
`ifdef SD_RD_CRC_EN
  logic [15:0]     crc;
  logic [7:0]      crc_hi;

  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {d, 8'h00};
    for (int i = 0; i < 8; i++) r = r[15] ? ({r[14:0], 1'b0} ^ 16'h1021) : {r[14:0], 1'b0};
    return r;
  endfunction
`endif

  function automatic logic [7:0] cmd_byte(input logic [2:0] idx, input logic [31:0] a);
    case (idx)
      3'd0:    return 8'h51;
      3'd1:    return a[31:24];
      3'd2:    return a[23:16];
      3'd3:    return a[15:8];
      3'd4:    return a[7:0];
      default: return 8'hFF;
    endcase
  endfunction

  assign nxt_cmd = cmd_byte(byte_cnt + 3'd1, addr);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sd_ck    <= 1'b0;
      sd_csn   <= 1'b1;
      sd_mosi  <= 1'b1;
      busy     <= 1'b0;
      rd_valid <= 1'b0;
      done     <= 1'b0;
      rd_data  <= 8'h00;
      err      <= 2'b00;
      div_cnt  <= '0;
      bit_cnt  <= 3'd0;
      tx_sr    <= 8'hFF;
      rx_sr    <= 8'h00;
      byte_cnt <= 3'd0;
      poll_cnt <= '0;
      data_cnt <= 9'd0;
      addr     <= 32'h0;
`ifdef SD_RD_CRC_EN
      crc      <= 16'h0;
      crc_hi   <= 8'h00;
`endif
    end else begin
      rd_valid <= 1'b0;
      done     <= 1'b0;
      if (state == IDLE) begin
        // busy is still high in the done cycle, so a start there is ignored
        if (start && init_ok && !busy) begin
          state    <= PRE;
          busy     <= 1'b1;
          sd_csn   <= 1'b0;
          sd_mosi  <= 1'b1;
          tx_sr    <= 8'hFF;
          addr     <= blk_addr;
          err      <= 2'b00;
          div_cnt  <= '0;
          bit_cnt  <= 3'd0;
          byte_cnt <= 3'd0;
          poll_cnt <= '0;
`ifdef SD_RD_CRC_EN
          crc      <= 16'h0;
`endif
        end else begin
          busy <= 1'b0;
        end
      end else if (div_cnt != DW'(CLK_DIV - 1)) begin
        div_cnt <= div_cnt + DW'(1);
      end else begin
        div_cnt <= '0;
        sd_ck   <= ~sd_ck;
        if (!sd_ck) begin
          rx_sr <= {rx_sr[6:0], sd_miso};
        end else if (bit_cnt != 3'd7) begin
          bit_cnt <= bit_cnt + 3'd1;
          tx_sr   <= {tx_sr[6:0], 1'b1};
          sd_mosi <= tx_sr[6];
        end else begin
          // byte boundary: rx_sr holds the full byte, next tx byte defaults to a poll
          bit_cnt <= 3'd0;
          tx_sr   <= 8'hFF;
          sd_mosi <= 1'b1;
          case (state)
            PRE: begin
              state    <= CMD;
              byte_cnt <= 3'd0;
              tx_sr    <= 8'h51;
              sd_mosi  <= 1'b0;
            end
            CMD: begin
              if (byte_cnt == 3'd5) begin
                state    <= R1;
                poll_cnt <= '0;
              end else begin
                byte_cnt <= byte_cnt + 3'd1;
                tx_sr    <= nxt_cmd;
                sd_mosi  <= nxt_cmd[7];
              end
            end
            R1: begin
              if (!rx_sr[7]) begin
                if (rx_sr == 8'h00) begin
                  state    <= TOKEN;
                  poll_cnt <= '0;
                end else begin
                  state  <= POST;
                  sd_csn <= 1'b1;
                  err    <= 2'b10;
                end
              end else if (poll_cnt == PW'(R1_TRIES - 1)) begin
                state  <= POST;
                sd_csn <= 1'b1;
                err    <= 2'b01;
              end else begin
                poll_cnt <= poll_cnt + PW'(1);
              end
            end
            TOKEN: begin
              if (rx_sr == 8'hFE) begin
                state    <= DATA;
                data_cnt <= 9'd0;
              end else if (rx_sr != 8'hFF || poll_cnt == PW'(TOKEN_TRIES - 1)) begin
                state  <= POST;
                sd_csn <= 1'b1;
                err    <= 2'b10;
              end else begin
                poll_cnt <= poll_cnt + PW'(1);
              end
            end
            DATA: begin
              rd_data  <= rx_sr;
              rd_valid <= 1'b1;
              data_cnt <= data_cnt + 9'd1;
`ifdef SD_RD_CRC_EN
              crc      <= crc16_byte(crc, rx_sr);
`endif
              if (data_cnt == 9'd511) begin
                state    <= CRC;
                byte_cnt <= 3'd0;
              end
            end
            CRC: begin
              if (byte_cnt == 3'd0) begin
                byte_cnt <= 3'd1;
`ifdef SD_RD_CRC_EN
                crc_hi   <= rx_sr;
`endif
              end else begin
                state  <= POST;
                sd_csn <= 1'b1;
`ifdef SD_RD_CRC_EN
                err    <= ({crc_hi, rx_sr} != crc) ? 2'b11 : 2'b00;
`else
                err    <= 2'b00;
`endif
              end
            end
            POST: begin
              state <= IDLE;
              done  <= 1'b1;
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end
endmodule

// File: tb/tb_sd_block_read.sv
// Bench for sd_block_read: behavioural SD card on the SPI pins plus a stream-level
// reference model that derives err, byte counts, data and timing from the response bytes.
module tb_sd_block_read;
  localparam int CD       = 2;
  localparam int R1T      = 8;
  localparam int TT       = 16;
  localparam int BYTE_CYC = 16 * CD;
  localparam int BOUND    = 30000;

  logic        clk = 1'b0;
  logic        rst, init_ok, start, sd_miso;
  logic [31:0] blk_addr;
  logic        sd_ck, sd_mosi, sd_csn, busy, rd_valid, done;
  logic [7:0]  rd_data;
  logic [1:0]  err;

  always #5 clk = ~clk;

  sd_block_read #(.CLK_DIV(CD), .R1_TRIES(R1T), .TOKEN_TRIES(TT)) dut (
    .clk(clk), .rst(rst), .init_ok(init_ok), .start(start), .blk_addr(blk_addr),
    .sd_ck(sd_ck), .sd_mosi(sd_mosi), .sd_csn(sd_csn), .sd_miso(sd_miso),
    .busy(busy), .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .err(err)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // output monitor
  logic [7:0] got_q[$];
  int         vld_cyc[$];
  int         done_cnt = 0;
  int         done_cyc = 0;
  logic [1:0] done_err;
  logic       done_csn, done_busy;

  always @(negedge clk) begin
    if (rd_valid) begin
      got_q.push_back(rd_data);
      vld_cyc.push_back(cyc);
    end
    if (done) begin
      done_cnt++;
      done_cyc  = cyc;
      done_err  = err;
      done_csn  = sd_csn;
      done_busy = busy;
    end
  end

  // card model: after PRE + 6 command bytes it plays resp_q, then 0xFF
  logic [7:0] resp_q[$];
  logic [7:0] mosi_q[$];
  logic [7:0] card_out = 8'hFF;
  logic [7:0] mosi_sr  = 8'h00;
  int         card_bit = 0;
  int         card_byte = 0;

  always @(negedge sd_csn) begin
    card_bit  = 0;
    card_byte = 0;
    card_out  = 8'hFF;
    sd_miso   = 1'b1;
  end
  always @(posedge sd_csn) sd_miso = 1'b1;
  always @(posedge sd_ck) if (!sd_csn) begin
    mosi_sr = {mosi_sr[6:0], sd_mosi};
    card_bit++;
    if (card_bit == 8) begin
      mosi_q.push_back(mosi_sr);
      card_bit = 0;
      card_byte++;
      if (card_byte >= 7 && resp_q.size() > 0) card_out = resp_q.pop_front();
      else card_out = 8'hFF;
    end
  end
  always @(negedge sd_ck) if (!sd_csn) sd_miso = card_out[7 - card_bit];

  // stimulus stream and reference model
  logic [7:0] stim_q[$];
  logic [7:0] crc_q[$];
  logic [7:0] exp_data[$];
  logic [1:0] exp_err;
  int         exp_nb, exp_first;

  function automatic logic [15:0] ref_crc();
    logic [15:0] c = 16'h0000;
    logic        fb;
    foreach (crc_q[k]) for (int j = 7; j >= 0; j--) begin
      fb = c[15] ^ crc_q[k][j];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h1021;
    end
    return c;
  endfunction

  function automatic logic [7:0] at(input int i);
    return (i < stim_q.size()) ? stim_q[i] : 8'hFF;
  endfunction

  task automatic build(input int r1d, input logic [7:0] r1v, input int tkd,
                       input logic [7:0] tkv, input bit rnd, input bit flip);
    logic [15:0] c;
    logic [7:0]  b;
    stim_q.delete();
    crc_q.delete();
    repeat (r1d) stim_q.push_back(8'hFF);
    stim_q.push_back(r1v);
    repeat (tkd) stim_q.push_back(8'hFF);
    stim_q.push_back(tkv);
    for (int k = 0; k < 512; k++) begin
      b = rnd ? 8'($urandom) : 8'(k);
      crc_q.push_back(b);
      stim_q.push_back(b);
    end
    c = ref_crc();
    if (flip) c = c ^ (16'h1 << $urandom_range(15, 0));
    stim_q.push_back(c[15:8]);
    stim_q.push_back(c[7:0]);
  endtask

  task automatic run_model();
    int         i = 0;
    bit         hit = 0;
    logic [7:0] b = 8'hFF;
`ifdef SD_RD_CRC_EN
    logic [15:0] rx_crc;
`endif
    exp_err = 2'b00;
    exp_first = 0;
    exp_data.delete();
    for (int t = 0; t < R1T; t++) begin
      b = at(i); i++;
      if (!b[7]) begin hit = 1; break; end
    end
    if (!hit) exp_err = 2'b01;
    else if (b != 8'h00) exp_err = 2'b10;
    else begin
      hit = 0;
      for (int t = 0; t < TT; t++) begin
        b = at(i); i++;
        if (b == 8'hFE) begin hit = 1; break; end
        if (b != 8'hFF) break;
      end
      if (!hit) exp_err = 2'b10;
      else begin
        exp_first = 7 + i;
        for (int k = 0; k < 512; k++) begin exp_data.push_back(at(i)); i++; end
`ifdef SD_RD_CRC_EN
        rx_crc = {at(i), at(i + 1)};
        crc_q = exp_data;
        if (rx_crc != ref_crc()) exp_err = 2'b11;
`endif
        i += 2;
      end
    end
    exp_nb = 7 + i;
  endtask

  task automatic chk_reset(input string tag);
    chk(tag, {sd_ck, sd_csn, sd_mosi, busy, rd_valid, done, rd_data, err},
        {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 2'b00});
  endtask

  task automatic launch(input logic [31:0] addr, output int st);
    run_model();
    resp_q = stim_q;
    mosi_q.delete(); got_q.delete(); vld_cyc.delete();
    done_cnt = 0;
    start = 1'b1; blk_addr = addr; st = cyc;
    tick();
    start = 1'b0; blk_addr = $urandom;
  endtask

  task automatic do_read(input string nm, input logic [31:0] addr, input bit poke);
    int st, w, bad;
    launch(addr, st);
    if (poke) begin
      repeat (100) tick();
      start = 1'b1; blk_addr = ~addr;
      tick();
      start = 1'b0;
    end
    w = 0;
    while (done_cnt == 0 && w < BOUND) begin tick(); w++; end
    chk({nm, ":done"}, done_cnt, 1);
    chk({nm, ":err"}, done_err, exp_err);
    chk({nm, ":csn_busy_at_done"}, {done_csn, done_busy}, 2'b11);
    chk({nm, ":done_time"}, done_cyc - st, BYTE_CYC * (exp_nb + 1) + 1);
    tick();
    chk({nm, ":busy_after_done"}, busy, 0);
    chk({nm, ":bytes"}, mosi_q.size(), exp_nb);
    if (mosi_q.size() >= 7) begin
      chk({nm, ":cmd_frame"}, {mosi_q[0], mosi_q[1], mosi_q[6]}, 24'hFF51FF);
      chk({nm, ":cmd_addr"}, {mosi_q[2], mosi_q[3], mosi_q[4], mosi_q[5]}, addr);
    end
    chk({nm, ":nvalid"}, got_q.size(), exp_data.size());
    bad = 0;
    foreach (exp_data[k]) if (k >= got_q.size() || got_q[k] !== exp_data[k]) bad++;
    chk({nm, ":data"}, bad, 0);
    if (vld_cyc.size() > 0) begin
      chk({nm, ":latency"}, vld_cyc[0] - st, BYTE_CYC * (exp_first + 1) + 1);
      bad = 0;
      for (int k = 1; k < vld_cyc.size(); k++) if (vld_cyc[k] - vld_cyc[k-1] != BYTE_CYC) bad++;
      chk({nm, ":spacing"}, bad, 0);
    end
    repeat (20) tick();
    chk({nm, ":idle"}, {done_cnt[7:0], busy, sd_csn, sd_mosi, sd_ck}, {8'd1, 4'b0110});
  endtask

  initial begin
    int st, w;
    rst = 1'b1; init_ok = 1'b1; start = 1'b0; blk_addr = 32'h0; sd_miso = 1'b1;
    repeat (3) tick();
    chk_reset("reset");
    rst = 1'b0;
    tick();

    build(2, 8'h00, 3, 8'hFE, 0, 0);
    do_read("nominal", 32'h0000_1234, 0);

    build(R1T - 1, 8'h00, TT - 1, 8'hFE, 1, 0);
    do_read("last_poll_ignored_start", $urandom, 1);

    build(R1T, 8'h00, 0, 8'hFE, 0, 0);
    do_read("r1_timeout", $urandom, 0);

    build(1, 8'h05, 0, 8'hFE, 0, 0);
    do_read("r1_err", $urandom, 0);

    build($urandom_range(3, 0), 8'h00, 1, 8'h08, 0, 0);
    do_read("data_err_token", $urandom, 0);

    build(0, 8'h00, TT, 8'hFE, 0, 0);
    do_read("token_timeout", $urandom, 0);

    build($urandom_range(3, 0), 8'h00, $urandom_range(4, 0), 8'hFE, 1, 1);
    do_read("crc_flip", $urandom, 0);

    init_ok = 1'b0; start = 1'b1; blk_addr = $urandom;
    tick();
    start = 1'b0;
    repeat (50) tick();
    chk("init_ok_low", {busy, sd_csn}, 2'b01);
    init_ok = 1'b1;

    build(1, 8'h00, 2, 8'hFE, 1, 0);
    launch($urandom, st);
    w = 0;
    while (got_q.size() < 100 && w < BOUND) begin tick(); w++; end
    chk("rst_mid:reached_byte100", got_q.size() >= 100, 1);
    rst = 1'b1;
    tick();
    chk_reset("rst_mid:outputs");
    rst = 1'b0;
    repeat (100) tick();
    chk("rst_mid:no_done", done_cnt, 0);

    build(0, 8'h00, 0, 8'hFE, 1, 0);
    do_read("after_rst_best_case", $urandom, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
